// File: rtl/gb_rtc_if.sv
// gb_rtc_if: mapper-side register/latch bus into the RTC engine
interface gb_rtc_if;
  logic       ce_cpu;
  logic [2:0] reg_sel;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       latch_wr;
  logic [7:0] latch_data;
  modport master (output ce_cpu, reg_sel, reg_wr, reg_wdata, latch_wr, latch_data, input reg_rdata);
  modport slave (input ce_cpu, reg_sel, reg_wr, reg_wdata, latch_wr, latch_data, output reg_rdata);
endinterface

// File: rtl/gb_rtc_engine.sv
// gb_rtc_engine: GB cartridge RTC with latched read view, unix stamp and save-restore catch-up
module gb_rtc_engine #(
  parameter int DAY_BITS = 9,
  parameter int TICK_HZ  = 32768,
  parameter int STAMP_W  = 32,
  localparam int TW = DAY_BITS + 19
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce_32k,
  gb_rtc_if.slave            bus,
  input  logic               stamp_load,
  input  logic [STAMP_W-1:0] stamp_now,
  input  logic               restore_valid,
  input  logic [STAMP_W-1:0] restore_stamp,
  input  logic [TW-1:0]      restore_time,
  output logic [TW-1:0]      live_time,
  output logic [STAMP_W-1:0] stamp_out,
  output logic               catchup_busy,
  output logic               time_changed
);
  localparam int PW = $clog2(TICK_HZ);
  localparam int HB = DAY_BITS - 8;
  localparam logic [PW-1:0] TMAX = PW'(TICK_HZ - 1);
  localparam logic [STAMP_W-1:0] S_DAY = STAMP_W'(86400);
  localparam logic [STAMP_W-1:0] S_HR = STAMP_W'(3600);
  localparam logic [STAMP_W-1:0] S_MIN = STAMP_W'(60);
  typedef enum logic {IDLE, CATCHUP} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, subsec;
  logic [5:0] sec, min, sec_l, min_l;
  logic [4:0] hr, hr_l;
  logic [DAY_BITS-1:0] days, days_l;
  logic halt, ovf, ovf_l, latch_f, tick_pend, pend_n;
  logic [STAMP_W-1:0] diff, diff_n, dec, rdiff;
  logic [1:0] lvl;
  logic wr, presc_wrap, sec_tick, adv, do_sec, do_min, do_hr, do_day;
  assign wr = bus.reg_wr & bus.ce_cpu & (bus.reg_sel <= 3'd4);
  assign presc_wrap = ce_32k & (presc == TMAX);
  assign sec_tick = (ce_32k & ~halt & (subsec == TMAX)) | tick_pend;
  assign rdiff = (stamp_out > restore_stamp) ? stamp_out - restore_stamp : '0;
  assign catchup_busy = state == CATCHUP;
  assign live_time = {halt, ovf, days, hr, min, sec};
  assign bus.reg_rdata = bus.reg_sel == 3'd0 ? {2'b0, sec_l} :
                         bus.reg_sel == 3'd1 ? {2'b0, min_l} :
                         bus.reg_sel == 3'd2 ? {3'b0, hr_l} :
                         bus.reg_sel == 3'd3 ? days_l[7:0] :
                         bus.reg_sel == 3'd4 ? {ovf_l, halt, 6'(days_l >> 8)} : 8'hFF;
  // lvl picks the unit the increment starts at; carries ripple upward from there
  assign do_sec = adv & (lvl == 2'd0);
  assign do_min = adv & ((lvl == 2'd1) | (do_sec & (sec == 6'd59)));
  assign do_hr = adv & ((lvl == 2'd2) | (do_min & (min == 6'd59)));
  assign do_day = adv & ((lvl == 2'd3) | (do_hr & (hr == 5'd23)));
  always_ff @(posedge clk_sys)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    diff_n = diff;
    pend_n = 1'b0;
    adv = 1'b0;
    lvl = 2'd0;
    dec = '0;
    if (restore_valid) begin
      diff_n = rdiff;
      state_n = rdiff != '0 ? CATCHUP : IDLE;
    end else if (state == IDLE) begin
      adv = sec_tick & ~halt & ~wr;
      pend_n = sec_tick & ~halt & wr & (bus.reg_sel != 3'd0);
    end else if (wr) begin
      diff_n = diff + STAMP_W'(sec_tick);
    end else if (halt) begin
      diff_n = '0;
      state_n = IDLE;
    end else if (diff == '0 && !sec_tick) begin
      state_n = IDLE;
    end else begin
      adv = diff != '0;
      lvl = diff >= S_DAY ? 2'd3 : diff >= S_HR ? 2'd2 : diff >= S_MIN ? 2'd1 : 2'd0;
      dec = !adv ? '0 : lvl == 2'd3 ? S_DAY : lvl == 2'd2 ? S_HR : lvl == 2'd1 ? S_MIN : STAMP_W'(1);
      diff_n = diff - dec + STAMP_W'(sec_tick);
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc <= '0;
      subsec <= '0;
      stamp_out <= '0;
      diff <= '0;
      tick_pend <= 1'b0;
      {halt, ovf, days, hr, min, sec} <= '0;
      {ovf_l, days_l, hr_l, min_l, sec_l} <= '0;
      latch_f <= 1'b0;
      time_changed <= 1'b0;
    end else begin
      presc <= presc_wrap ? '0 : presc + PW'(ce_32k);
      stamp_out <= stamp_load ? stamp_now : stamp_out + STAMP_W'(presc_wrap);
      diff <= diff_n;
      tick_pend <= pend_n;
      time_changed <= restore_valid | wr | adv;
      if (restore_valid) begin
        {halt, ovf, days, hr, min, sec} <= restore_time;
        subsec <= '0;
      end else begin
        if (wr && bus.reg_sel == 3'd0)
          subsec <= '0;
        else if (ce_32k && !halt)
          subsec <= subsec == TMAX ? '0 : subsec + 1'b1;
        if (wr) begin
          case (bus.reg_sel)
            3'd0: sec <= bus.reg_wdata[5:0];
            3'd1: min <= bus.reg_wdata[5:0];
            3'd2: hr <= bus.reg_wdata[4:0];
            3'd3: days[7:0] <= bus.reg_wdata;
            default: {ovf, halt, days[DAY_BITS-1:8]} <= {bus.reg_wdata[7:6], bus.reg_wdata[HB-1:0]};
          endcase
        end else begin
          if (do_sec) sec <= sec == 6'd59 ? 6'd0 : sec + 1'b1;
          if (do_min) min <= min == 6'd59 ? 6'd0 : min + 1'b1;
          if (do_hr) hr <= hr == 5'd23 ? 5'd0 : hr + 1'b1;
          if (do_day) days <= days + 1'b1;
          if (do_day && &days) ovf <= 1'b1;
        end
      end
      if (bus.latch_wr && bus.ce_cpu && bus.latch_data[7:1] == 7'd0) begin
        latch_f <= bus.latch_data[0];
        if (!latch_f && bus.latch_data[0])
          {ovf_l, days_l, hr_l, min_l, sec_l} <= {ovf, days, hr, min, sec};
      end
    end
  end
endmodule

// File: tb/tb_gb_rtc_engine.sv
// tb_gb_rtc_engine: directed stimulus checked every cycle against a unit-level RTC model
module tb_gb_rtc_engine;
  localparam int DB = 9, T = 16, SW = 32, TW = DB + 19;
  logic clk_sys = 1'b0, reset = 1'b1, ce_32k = 1'b0, stamp_load = 1'b0, restore_valid = 1'b0;
  logic [SW-1:0] stamp_now = '0, restore_stamp = '0, stamp_out;
  logic [TW-1:0] restore_time = '0, live_time;
  logic catchup_busy, time_changed;
  int n_chk = 0, n_fail = 0, tc_cnt = 0;
  bit chk_en = 1'b0;
  gb_rtc_if bus();
  gb_rtc_engine #(.DAY_BITS(DB), .TICK_HZ(T), .STAMP_W(SW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_32k(ce_32k), .bus(bus),
    .stamp_load(stamp_load), .stamp_now(stamp_now), .restore_valid(restore_valid),
    .restore_stamp(restore_stamp), .restore_time(restore_time), .live_time(live_time),
    .stamp_out(stamp_out), .catchup_busy(catchup_busy), .time_changed(time_changed));
  always #5 clk_sys = ~clk_sys;
  // model: u[] holds sec/min/hr/day as plain integers, ul[] the latched view
  int u[4], ul[4];
  int wrapv[4] = '{59, 59, 23, (1 << DB) - 1};
  int modv[4] = '{64, 64, 32, 1 << DB};
  int span[4] = '{1, 60, 3600, 86400};
  bit m_halt, m_ovf, m_ovfl, m_lf, m_busy, m_pend, m_tc;
  int m_presc, m_sub;
  logic [SW-1:0] m_stamp, m_diff;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic bump(input int l);
    for (int k = l; k < 4; k++) begin
      if (u[k] == wrapv[k]) begin
        u[k] = 0;
        if (k == 3) m_ovf = 1'b1;
      end else begin
        u[k] = (u[k] + 1) % modv[k];
        break;
      end
    end
  endtask
  task automatic model_write(input logic [2:0] s, input logic [7:0] d);
    case (s)
      0: u[0] = int'(d[5:0]);
      1: u[1] = int'(d[5:0]);
      2: u[2] = int'(d[4:0]);
      3: u[3] = u[3] - u[3] % 256 + int'(d);
      default: begin
        u[3] = u[3] % 256 + 256 * (int'(d) % (1 << (DB - 8)));
        m_halt = d[6];
        m_ovf = d[7];
      end
    endcase
  endtask
  function automatic logic [TW-1:0] m_time();
    return {m_halt, m_ovf, DB'(u[3]), 5'(u[2]), 6'(u[1]), 6'(u[0])};
  endfunction
  function automatic logic [7:0] m_rdata(input logic [2:0] s);
    case (s)
      0: return 8'(ul[0]);
      1: return 8'(ul[1]);
      2: return 8'(ul[2]);
      3: return 8'(ul[3] % 256);
      4: return {m_ovfl, m_halt, 6'(ul[3] / 256)};
      default: return 8'hFF;
    endcase
  endfunction
  always @(posedge clk_sys) begin
    bit wr, tk, pw, h0;
    int k;
    logic [SW-1:0] st0;
    if (reset) begin
      u = '{0, 0, 0, 0};
      ul = '{0, 0, 0, 0};
      {m_halt, m_ovf, m_ovfl, m_lf, m_busy, m_pend, m_tc} = '0;
      m_presc = 0;
      m_sub = 0;
      m_stamp = '0;
      m_diff = '0;
    end else begin
      wr = bus.reg_wr && bus.ce_cpu && bus.reg_sel <= 3'd4;
      h0 = m_halt;
      st0 = m_stamp;
      pw = ce_32k && m_presc == T - 1;
      tk = (ce_32k && !m_halt && m_sub == T - 1) || m_pend;
      m_tc = 1'b0;
      m_pend = 1'b0;
      if (bus.latch_wr && bus.ce_cpu && bus.latch_data[7:1] == 7'd0) begin
        if (!m_lf && bus.latch_data[0]) begin
          ul = u;
          m_ovfl = m_ovf;
        end
        m_lf = bus.latch_data[0];
      end
      if (ce_32k) m_presc = (m_presc + 1) % T;
      m_stamp = stamp_load ? stamp_now : m_stamp + SW'(pw);
      if (restore_valid) begin
        m_halt = restore_time[TW-1];
        m_ovf = restore_time[TW-2];
        u[3] = int'(restore_time[TW-3:17]);
        u[2] = int'(restore_time[16:12]);
        u[1] = int'(restore_time[11:6]);
        u[0] = int'(restore_time[5:0]);
        m_sub = 0;
        m_diff = st0 > restore_stamp ? st0 - restore_stamp : '0;
        m_busy = m_diff != 0;
        m_tc = 1'b1;
      end else begin
        if (wr && bus.reg_sel == 3'd0) m_sub = 0;
        else if (ce_32k && !h0) m_sub = (m_sub + 1) % T;
        if (wr) begin
          model_write(bus.reg_sel, bus.reg_wdata);
          m_tc = 1'b1;
        end
        if (m_busy) begin
          if (wr) m_diff = m_diff + SW'(tk);
          else if (h0) begin
            m_diff = '0;
            m_busy = 1'b0;
          end else if (m_diff == 0 && !tk) m_busy = 1'b0;
          else if (m_diff == 0) m_diff = 1;
          else begin
            k = 3;
            while (m_diff < SW'(span[k])) k--;
            bump(k);
            m_diff = m_diff - SW'(span[k]) + SW'(tk);
            m_tc = 1'b1;
          end
        end else if (tk && !h0) begin
          if (wr) m_pend = bus.reg_sel != 3'd0;
          else begin
            bump(0);
            m_tc = 1'b1;
          end
        end
      end
    end
  end
  always @(negedge clk_sys) if (chk_en) begin
    check("live_time", live_time, m_time());
    check("stamp_out", stamp_out, m_stamp);
    check("catchup_busy", catchup_busy, m_busy);
    check("time_changed", time_changed, m_tc);
    check("reg_rdata", bus.reg_rdata, m_rdata(bus.reg_sel));
    if (time_changed) tc_cnt++;
  end
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic tick(input int n);
    ce_32k = 1'b1;
    repeat (n) cyc();
    ce_32k = 1'b0;
  endtask
  task automatic wreg(input logic [2:0] s, input logic [7:0] d);
    bus.reg_sel = s;
    bus.reg_wdata = d;
    bus.reg_wr = 1'b1;
    bus.ce_cpu = 1'b1;
    cyc();
    bus.reg_wr = 1'b0;
    bus.ce_cpu = 1'b0;
  endtask
  task automatic latch(input logic [7:0] d);
    bus.latch_data = d;
    bus.latch_wr = 1'b1;
    bus.ce_cpu = 1'b1;
    cyc();
    bus.latch_wr = 1'b0;
    bus.ce_cpu = 1'b0;
  endtask
  task automatic restore(input logic [SW-1:0] now, input logic [SW-1:0] rs, input logic [TW-1:0] rt);
    stamp_now = now;
    stamp_load = 1'b1;
    cyc();
    stamp_load = 1'b0;
    restore_stamp = rs;
    restore_time = rt;
    restore_valid = 1'b1;
    cyc();
    restore_valid = 1'b0;
  endtask
  task automatic run_catchup(input bit wr_first, output int n);
    n = 0;
    while (catchup_busy && n < 50) begin
      n++;
      if (wr_first && n == 1) begin
        bus.reg_sel = 3'd0;
        bus.reg_wdata = 8'd0;
        bus.reg_wr = 1'b1;
        bus.ce_cpu = 1'b1;
      end
      cyc();
      bus.reg_wr = 1'b0;
      bus.ce_cpu = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.ce_cpu = 1'b0;
    bus.reg_sel = 3'd0;
    bus.reg_wr = 1'b0;
    bus.reg_wdata = 8'd0;
    bus.latch_wr = 1'b0;
    bus.latch_data = 8'd0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_live", live_time, 28'h0);
    check("reset_stamp", stamp_out, 32'd0);
    check("reset_busy", catchup_busy, 1'b0);
    for (int s = 0; s < 6; s++) begin
      bus.reg_sel = 3'(s);
      #1 check("reset_rdata", bus.reg_rdata, s < 5 ? 8'h00 : 8'hFF);
    end
    reset = 1'b0;
    tc_cnt = 0;
    tick(T);
    cyc();
    cyc();
    check("one_second_live", live_time, 28'h1);
    check("one_second_stamp", stamp_out, 32'd1);
    check("one_second_pulses", tc_cnt, 1);
    wreg(3'd0, 8'd59);
    wreg(3'd1, 8'd59);
    wreg(3'd2, 8'd23);
    wreg(3'd3, 8'hFF);
    wreg(3'd4, 8'h01);
    wreg(3'd5, 8'hAA);
    tick(T);
    check("rollover_live", live_time, 28'h400_0000);
    latch(8'h01);
    bus.reg_sel = 3'd4;
    #1 check("rollover_rdata4", bus.reg_rdata, 8'h80);
    wreg(3'd4, 8'h40);
    tick(2 * T);
    check("halt_live", live_time, 28'h800_0000);
    check("halt_stamp", stamp_out, 32'd4);
    wreg(3'd0, 8'd63);
    check("sec63_live", live_time, 28'h800_003F);
    wreg(3'd4, 8'h00);
    tick(T);
    check("sec63_wrap", live_time, 28'h0);
    check("sec63_stamp", stamp_out, 32'd5);
    restore(32'd100000, 32'd10000, 28'h0);
    run_catchup(1'b0, n);
    check("catchup_cycles", n, 3);
    check("catchup_live", live_time, 28'h002_1000);
    wreg(3'd0, 8'd5);
    latch(8'h00);
    latch(8'h01);
    tick(T);
    latch(8'h01);
    bus.reg_sel = 3'd0;
    #1 check("latch_second_ignored", bus.reg_rdata, 8'd5);
    latch(8'h00);
    latch(8'h03);
    tick(T);
    bus.reg_sel = 3'd0;
    #1 check("latch_bad_ignored", bus.reg_rdata, 8'd5);
    latch(8'h01);
    bus.reg_sel = 3'd0;
    #1 check("latch_fourth_copy", bus.reg_rdata, 8'd7);
    restore(32'd20000, 32'd19500, 28'h80A_3107);
    run_catchup(1'b0, n);
    check("halt_catchup_cycles", n, 1);
    check("halt_catchup_live", live_time, 28'h80A_3107);
    restore(32'd100000, 32'd10000, 28'h0);
    run_catchup(1'b1, n);
    check("wr_catchup_cycles", n, 4);
    check("wr_catchup_live", live_time, 28'h002_1000);
    restore(32'd100000, 32'd10000, 28'h0);
    cyc();
    reset = 1'b1;
    cyc();
    check("reset_mid_busy", catchup_busy, 1'b0);
    check("reset_mid_live", live_time, 28'h0);
    check("reset_mid_stamp", stamp_out, 32'd0);
    reset = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gb_rtc_engine.md
Name: gb_rtc_engine

Overview:
- Parametrised real-time-clock engine shared by the GB cartridge mappers: MBC3/MBC30 with DAY_BITS=9, and wider day counters for later mappers.
- Holds live sec/min/hr/day/halt/overflow registers and a latched read view.
- Keeps a free-running unix timestamp for save files.
- After a save restore, replays elapsed time with a multi-cycle catch-up engine that steps whole days/hours/minutes/seconds, not one second per cycle.
- Sits beside the mapper register decode; the mapper drives reg_sel/reg_wr/latch_wr and muxes reg_rdata onto cram_do.

Parameters:
DAY_BITS, 9, day counter width (9..14); TW = DAY_BITS+19.
TICK_HZ, 32768, ce_32k pulses per second.
STAMP_W, 32, timestamp width.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_32k  in  1  32.768 kHz tick enable
ce_cpu  in  1  CPU clock enable; qualifies reg_wr and latch_wr
reg_sel  in  3  0 sec, 1 min, 2 hr, 3 day[7:0], 4 day-high/flags
reg_wr  in  1  write reg_wdata to live register reg_sel
reg_wdata  in  8  write data
reg_rdata  out  8  latched register selected by reg_sel (combinational)
latch_wr  in  1  write to latch register
latch_data  in  8  latch write data
stamp_load  in  1  pulse: stamp_out <= stamp_now
stamp_now  in  STAMP_W  host unix time
restore_valid  in  1  pulse: load restore_time/restore_stamp
restore_stamp  in  STAMP_W  timestamp stored in save file
restore_time  in  TW  {halt, ovf, days, hr[4:0], min[5:0], sec[5:0]}
live_time  out  TW  live registers, same packing
stamp_out  out  STAMP_W  running timestamp
catchup_busy  out  1  catch-up in progress
time_changed  out  1  one-cycle pulse when live registers are modified

Behaviour:
- Reset values: all time regs, latched copies, halt, ovf, subsec, prescaler, stamp_out, diff = 0; latch flag 0; state IDLE; catchup_busy 0; time_changed 0; reg_rdata = 0 for sel 0..4.
- Prescaler: 15-bit counter on ce_32k, never halted; wraps at TICK_HZ-1 and increments stamp_out. stamp_load overrides the increment in that cycle.
- Subsec counter:
  - advances on ce_32k only when halt=0;
  - wrap at TICK_HZ-1 gives a second tick;
  - a sec write clears it.
- Unit increment rule:
  - sec: 59 wraps to 0 with carry to min; any other value goes to value+1 mod 64 with no carry (so 63 -> 0, no carry).
  - min: same rule as sec, carry to hr.
  - hr: 23 wraps to 0 with carry to days; otherwise +1 mod 32.
  - days: all-ones wraps to 0 and sets ovf=1 (sticky).
- Second tick: in IDLE with halt=0, apply the sec increment. In CATCHUP, do diff += 1 instead.
- Writes (reg_wr & ce_cpu):
  - sel 0/1/2 load wdata[5:0]/[5:0]/[4:0]; sel 3 loads days[7:0].
  - sel 4: days[DAY_BITS-1:8] <= wdata[DAY_BITS-9:0], halt <= wdata[6], ovf <= wdata[7].
  - sel 5..7 are ignored.
  - A write wins over a tick or catch-up step in the same cycle; that step is skipped and retried next cycle.
- Read view:
  - sel 0..3 return zero-extended latched values.
  - sel 4 returns {ovf_l, halt (live), zeros, days_l[DAY_BITS-1:8]}.
  - sel 5..7 return 8'hFF.
- Latch (latch_wr & ce_cpu): writes with latch_data[7:1] != 0 are ignored.
  - Otherwise latch flag <= latch_data[0].
  - A 0->1 transition copies live sec/min/hr/days/ovf into the latched copies in that cycle.
- Restore (restore_valid): has priority over writes and ticks.
  - Load the live regs from restore_time; clear subsec.
  - diff <= (stamp_out > restore_stamp) ? stamp_out - restore_stamp : 0.
  - Next state is CATCHUP if diff != 0, else IDLE.
- CATCHUP: catchup_busy = 1. Each cycle without a write:
  - if halt=1: diff <= 0, go to IDLE;
  - else if diff >= 86400: days step, diff -= 86400;
  - else if diff >= 3600: hr step;
  - else if diff >= 60: min step;
  - else: sec step, diff -= 1.
  - Each step increments that unit with carry upward and leaves lower units unchanged.
  - Go to IDLE in the cycle diff reaches 0.
  - A restore_valid during CATCHUP restarts it.
- time_changed: asserted the cycle after any live-register modification (tick, step, write, restore).
- Reset mid-catch-up: returns to IDLE with all reset values on the next edge.

Test Plan:
- Reset, 32768 ce_32k pulses, halt=0 -> live sec=1, stamp_out=1, one time_changed pulse.
- Write sel0=59, sel1=59, sel2=23, sel3=0xFF, sel4=0x01, then one second tick -> all time regs 0, ovf=1, reg_rdata(sel4) after latch 0->1 = 0x80.
- Write sel4=0x40 (halt), 65536 ticks -> live sec unchanged, stamp_out += 2; write sec=63, clear halt, one second -> sec=0, min unchanged.
- stamp_out=100000, restore_stamp=10000, restore_time all 0 -> catch-up ends with days=1, hr=1, min=0, sec=0; catchup_busy high exactly 3 cycles (86400+3600 = 90000).
- Latch writes 1,1,0,1 with the clock ticking -> copies taken only on the 1st and 4th writes; latch_data=0x03 ignored.
- restore with halt bit=1 and diff=500 -> catch-up exits after 1 cycle, time equals restore_time; a reg_wr during a multi-cycle catch-up delays completion by exactly one cycle.
